// File: rtl/fft_chk_pkg.sv
// Shared types and helpers for the FFT output-stream checker.
// The optional natural-order readout is enabled with FFT_CHK_REORDER_EN.
package fft_chk_pkg;

   localparam int N_DEF   = 128;
   localparam int DW_DEF  = 16;
   localparam int TOL_DEF = 2;
   localparam int AW_MAX  = 12;
   localparam int DMAX    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Reverse the low nn bits of v; upper result bits are zero.
   function automatic logic [AW_MAX-1:0] bitrev(input logic [AW_MAX-1:0] v, input int nn);
      logic [AW_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < AW_MAX; i++) begin
         r[AW_MAX-1-i] = v[i];
      end
      return r >> (AW_MAX - nn);
   endfunction

   function automatic logic [DMAX-1:0] abs_diff(input logic signed [DMAX-1:0] a,
                                                input logic signed [DMAX-1:0] b);
      logic signed [DMAX-1:0] d;
      d = a - b;
      return (d < 0) ? -d : d;
   endfunction

endpackage

// File: rtl/fft_chk_reorder_buf.sv
// Ping-pong sample buffer that replays a completed frame in natural order.
// Only instantiated when FFT_CHK_REORDER_EN is defined.
module fft_chk_reorder_buf
   import fft_chk_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   localparam int NN = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [NN-1:0] wr_addr,
   input  logic [DW-1:0] wr_re,
   input  logic [DW-1:0] wr_im,
   input  logic          frame_end,
   input  logic          start,
   input  logic          di_en,
   output logic          do_en,
   output logic [DW-1:0] do_re,
   output logic [DW-1:0] do_im,
   output logic          overrun
);

   logic [DW-1:0] mem_re [2*N];
   logic [DW-1:0] mem_im [2*N];
   logic          wr_bank;
   logic          rd_bank;
   logic [NN-1:0] rd_cnt;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_re[{wr_bank, wr_addr}] <= wr_re;
         mem_im[{wr_bank, wr_addr}] <= wr_im;
      end
   end

   // The frame that just finished lives in the bank not currently being written.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         rd_cnt  <= '0;
         do_en   <= 1'b0;
         do_re   <= '0;
         do_im   <= '0;
         overrun <= 1'b0;
      end else begin
         if (frame_end) wr_bank <= ~wr_bank;
         if (di_en && do_en) overrun <= 1'b1;
         if (start) begin
            do_en   <= 1'b1;
            rd_bank <= ~wr_bank;
            rd_cnt  <= NN'(1);
            do_re   <= mem_re[{~wr_bank, NN'(0)}];
            do_im   <= mem_im[{~wr_bank, NN'(0)}];
         end else if (do_en) begin
            if (rd_cnt == '0) begin
               do_en <= 1'b0;
            end else begin
               do_re  <= mem_re[{rd_bank, rd_cnt}];
               do_im  <= mem_im[{rd_bank, rd_cnt}];
               rd_cnt <= rd_cnt + NN'(1);
            end
         end
      end
   end

endmodule

// File: rtl/fft_stream_checker.sv
// Compares a bit-reversed FFT output frame against a golden ROM within +/-TOL.
// Define FFT_CHK_REORDER_EN to add the natural-order readout buffer.
//
// state | meaning
// IDLE  | waiting for sample 0 of a frame
// RUN   | accepting samples 0..N-1
// FLUSH | draining the 2-stage compare pipeline; done on the third cycle
module fft_stream_checker
   import fft_chk_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int DW   = DW_DEF,
   parameter int TOL  = TOL_DEF,
   parameter int ERRW = 8,
   localparam int NN  = $clog2(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            di_en,
   input  logic [DW-1:0]   di_re,
   input  logic [DW-1:0]   di_im,
   output logic [NN-1:0]   gold_addr,
   input  logic [DW-1:0]   gold_re,
   input  logic [DW-1:0]   gold_im,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_cnt,
   output logic [DW:0]     max_err,
   output logic [15:0]     frame_cnt,
   output logic            do_en,
   output logic [DW-1:0]   do_re,
   output logic [DW-1:0]   do_im,
   output logic            overrun
);

   localparam int AW  = DW + 1;
   localparam int EW1 = ERRW + 1;

   state_t          state, state_nx;
   logic [1:0]      fl_cnt, fl_cnt_nx;
   logic            pend, pend_nx;
   logic            accept, ro_busy, wrap;
   logic [NN-1:0]   k;

   logic            v1, first1, last1;
   logic [DW-1:0]   d1_re, d1_im;
   logic            v2, first2, last2;
   logic [AW-1:0]   a2_re, a2_im;
   logic            e2_re, e2_im;

   logic [DMAX-1:0] ad_re, ad_im;
   logic [1:0]      inc;
   logic [ERRW-1:0] err_base, err_nx;
   logic [ERRW:0]   err_sum;
   logic [AW-1:0]   max_nx;

   assign accept    = di_en && !ro_busy;
   assign wrap      = accept && (k == NN'(N - 1));
   assign gold_addr = NN'(bitrev(AW_MAX'(k), NN));
   assign busy      = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         fl_cnt <= '0;
         pend   <= 1'b0;
      end else begin
         state  <= state_nx;
         fl_cnt <= fl_cnt_nx;
         pend   <= pend_nx;
      end
   end

   // A sample arriving during FLUSH starts the next frame; pend remembers it.
   always_comb begin
      state_nx  = state;
      fl_cnt_nx = fl_cnt;
      pend_nx   = pend;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nx = RUN;
         end
         RUN: begin
            if (wrap) begin
               state_nx  = FLUSH;
               fl_cnt_nx = '0;
               pend_nx   = 1'b0;
            end
         end
         FLUSH: begin
            if (accept) pend_nx = 1'b1;
            if (fl_cnt == 2'd2) begin
               done     = 1'b1;
               state_nx = (pend || accept) ? RUN : IDLE;
               pend_nx  = 1'b0;
            end else begin
               fl_cnt_nx = fl_cnt + 2'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ad_re = abs_diff(DMAX'($signed(d1_re)), DMAX'($signed(gold_re)));
   assign ad_im = abs_diff(DMAX'($signed(d1_im)), DMAX'($signed(gold_im)));
   assign inc   = {1'b0, e2_re} + {1'b0, e2_im};

   // Sample 0 of a frame restarts the accumulation, so frames never mix.
   always_comb begin
      err_base = first2 ? '0 : err_cnt;
      err_sum  = {1'b0, err_base} + EW1'(inc);
      err_nx   = err_sum[ERRW] ? '1 : err_sum[ERRW-1:0];
      max_nx   = first2 ? '0 : max_err;
      if (a2_re > max_nx) max_nx = a2_re;
      if (a2_im > max_nx) max_nx = a2_im;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         k         <= '0;
         v1        <= 1'b0;
         first1    <= 1'b0;
         last1     <= 1'b0;
         d1_re     <= '0;
         d1_im     <= '0;
         v2        <= 1'b0;
         first2    <= 1'b0;
         last2     <= 1'b0;
         a2_re     <= '0;
         a2_im     <= '0;
         e2_re     <= 1'b0;
         e2_im     <= 1'b0;
         err_cnt   <= '0;
         max_err   <= '0;
         pass      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         v1     <= accept;
         first1 <= accept && (k == '0);
         last1  <= wrap;
         if (accept) begin
            d1_re <= di_re;
            d1_im <= di_im;
            k     <= k + NN'(1);
         end
         v2     <= v1;
         first2 <= first1;
         last2  <= last1;
         if (v1) begin
            a2_re <= AW'(ad_re);
            a2_im <= AW'(ad_im);
            e2_re <= (ad_re > DMAX'(TOL));
            e2_im <= (ad_im > DMAX'(TOL));
         end
         if (accept && state == IDLE) begin
            err_cnt <= '0;
            max_err <= '0;
         end
         if (v2) begin
            err_cnt <= err_nx;
            max_err <= max_nx;
            if (last2) begin
               pass      <= (err_nx == '0);
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
      end
   end

`ifdef FFT_CHK_REORDER_EN
   fft_chk_reorder_buf #(.N(N), .DW(DW)) u_reorder (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (accept),
      .wr_addr   (gold_addr),
      .wr_re     (di_re),
      .wr_im     (di_im),
      .frame_end (wrap),
      .start     (done),
      .di_en     (di_en),
      .do_en     (do_en),
      .do_re     (do_re),
      .do_im     (do_im),
      .overrun   (overrun)
   );
   assign ro_busy = do_en;
`else
   assign do_en   = 1'b0;
   assign do_re   = '0;
   assign do_im   = '0;
   assign overrun = 1'b0;
   assign ro_busy = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stream_checker.sv
// Directed bench for fft_stream_checker (N=128, DW=16, TOL=2, ERRW=8).
// The readout scenario is built only when FFT_CHK_REORDER_EN is defined.
module tb_fft_stream_checker;

   logic               clock = 1'b0;
   logic               reset;
   logic               di_en;
   logic signed [15:0] di_re, di_im;
   logic [6:0]         gold_addr;
   logic signed [15:0] gold_re, gold_im;
   logic               busy, done, pass;
   logic [7:0]         err_cnt;
   logic [16:0]        max_err;
   logic [15:0]        frame_cnt;
   logic               do_en;
   logic [15:0]        do_re, do_im;
   logic               overrun;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   fft_stream_checker dut (
      .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .gold_addr(gold_addr), .gold_re(gold_re), .gold_im(gold_im),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .max_err(max_err),
      .frame_cnt(frame_cnt), .do_en(do_en), .do_re(do_re), .do_im(do_im), .overrun(overrun)
   );

   function automatic int g_re(input int a); return a * 5 - 300; endfunction
   function automatic int g_im(input int a); return 400 - a * 3; endfunction

   always_ff @(posedge clock) begin
      gold_re <= 16'(g_re(int'(gold_addr)));
      gold_im <= 16'(g_im(int'(gold_addr)));
   end

   function automatic int tb_rev(input int v);
      int r = 0;
      for (int i = 0; i < 7; i++) r |= ((v >> i) & 1) << (6 - i);
      return r;
   endfunction

   // mode 0 exact, 1 +/-2 on re, 2 +3 on samples 5 and 77, 3 +100 everywhere
   function automatic int err_of(input int mode, input int k, input int c);
      case (mode)
         1: return (c == 0) ? ((k % 2 == 0) ? 2 : -2) : 0;
         2: return (k == 5 || k == 77) ? 3 : 0;
         3: return 100;
         default: return 0;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int mode, input int k);
      int a;
      a = tb_rev(k);
      di_re = 16'(g_re(a) + err_of(mode, k, 0));
      di_im = 16'(g_im(a) + err_of(mode, k, 1));
      di_en = 1'b1;
   endtask

   task automatic wait_readout_idle();
      for (int w = 0; w < 300 && do_en; w++) step();
   endtask

   task automatic send_frame(input string name, input int mode, input bit gaps,
                             input int exp_err, input int exp_max, input bit exp_pass,
                             input int exp_fc);
      int early_done = 0;
      wait_readout_idle();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL %s busy_before got=%b want=0", name, busy);
      else n_pass++;
      for (int k = 0; k < 128; k++) begin
         if (gaps && k > 0) begin
            di_en = 1'b0;
            step();
            if (done) early_done++;
         end
         drive(mode, k);
         step();
         if (done) early_done++;
         if (k == 0) begin
            n_checks++;
            if (busy !== 1'b1) $display("FAIL %s busy_after_first got=%b want=1", name, busy);
            else n_pass++;
         end
      end
      di_en = 1'b0;
      n_checks++;
      if (early_done !== 0) $display("FAIL %s early_done got=%0d want=0", name, early_done);
      else n_pass++;
      step();
      n_checks++;
      if (done !== 1'b0) $display("FAIL %s done_at_t+2 got=%b want=0", name, done);
      else n_pass++;
      step();
      n_checks++;
      if (done !== 1'b1) $display("FAIL %s done_at_t+3 got=%b want=1", name, done);
      else n_pass++;
      n_checks++;
      if (err_cnt !== 8'(exp_err)) $display("FAIL %s err_cnt got=%0d want=%0d", name, err_cnt, exp_err);
      else n_pass++;
      n_checks++;
      if (max_err !== 17'(exp_max)) $display("FAIL %s max_err got=%0d want=%0d", name, max_err, exp_max);
      else n_pass++;
      n_checks++;
      if (pass !== exp_pass) $display("FAIL %s pass got=%b want=%b", name, pass, exp_pass);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== 16'(exp_fc)) $display("FAIL %s frame_cnt got=%0d want=%0d", name, frame_cnt, exp_fc);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL %s busy_in_done got=%b want=1", name, busy);
      else n_pass++;
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s after_done done=%b busy=%b want 0/0", name, done, busy);
      else n_pass++;
      n_checks++;
      if (err_cnt !== 8'(exp_err) || max_err !== 17'(exp_max))
         $display("FAIL %s hold err=%0d max=%0d want %0d/%0d", name, err_cnt, max_err, exp_err, exp_max);
      else n_pass++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      di_en = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({busy, done, pass, do_en, overrun} !== 5'b0 || err_cnt !== 8'd0 || max_err !== 17'd0 ||
          frame_cnt !== 16'd0 || gold_addr !== 7'd0 || do_re !== 16'd0 || do_im !== 16'd0)
         $display("FAIL %s outputs busy=%b done=%b pass=%b err=%0d max=%0d fc=%0d addr=%0d do_en=%b ovr=%b want all 0",
                  name, busy, done, pass, err_cnt, max_err, frame_cnt, gold_addr, do_en, overrun);
      else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      check_zero("reset");
   endtask

   task automatic test_exact();       send_frame("exact",  0, 1'b0, 0,   0,   1'b1, 1); endtask
   task automatic test_window_edge(); send_frame("window", 1, 1'b0, 0,   2,   1'b1, 2); endtask
   task automatic test_plus3();       send_frame("plus3",  2, 1'b0, 4,   3,   1'b0, 3); endtask
   task automatic test_saturation();  send_frame("sat",    3, 1'b0, 255, 100, 1'b0, 4); endtask
   task automatic test_gaps();        send_frame("gaps",   2, 1'b1, 4,   3,   1'b0, 5); endtask

   task automatic test_back_to_back();
      int n_done = 0;
      int cyc = 0;
      int dc[2];
      int de[2];
      bit dp[2];
      do_reset();
      for (int i = 0; i < 262; i++) begin
         if (i < 256) drive((i < 128) ? 2 : 0, i % 128);
         else di_en = 1'b0;
         step();
         cyc++;
         if (done) begin
            if (n_done < 2) begin
               dc[n_done] = cyc;
               de[n_done] = int'(err_cnt);
               dp[n_done] = pass;
            end
            n_done++;
         end
      end
      n_checks++;
      if (n_done !== 2) $display("FAIL b2b done_count got=%0d want=2", n_done);
      else n_pass++;
      if (n_done >= 2) begin
         n_checks++;
         if (dc[1] - dc[0] !== 128) $display("FAIL b2b done_spacing got=%0d want=128", dc[1] - dc[0]);
         else n_pass++;
         n_checks++;
         if (de[0] !== 4 || dp[0] !== 1'b0) $display("FAIL b2b frame1 err=%0d pass=%b want 4/0", de[0], dp[0]);
         else n_pass++;
         n_checks++;
         if (de[1] !== 0 || dp[1] !== 1'b1) $display("FAIL b2b frame2 err=%0d pass=%b want 0/1", de[1], dp[1]);
         else n_pass++;
      end
      n_checks++;
      if (frame_cnt !== 16'd2) $display("FAIL b2b frame_cnt got=%0d want=2", frame_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      wait_readout_idle();
      for (int k = 0; k < 60; k++) begin
         drive(3, k);
         step();
      end
      di_en = 1'b0;
      n_checks++;
      if (err_cnt === 8'd0) $display("FAIL reset_mid pre_err got=%0d want nonzero", err_cnt);
      else n_pass++;
      reset = 1'b1;
      step();
      check_zero("reset_mid");
      reset = 1'b0;
      step();
      send_frame("after_reset", 0, 1'b0, 0, 0, 1'b1, 1);
   endtask

`ifdef FFT_CHK_REORDER_EN
   task automatic test_reorder();
      int bad = 0;
      do_reset();
      send_frame("reorder", 0, 1'b0, 0, 0, 1'b1, 1);
      for (int n = 0; n < 128; n++) begin
         if (do_en !== 1'b1 || do_re !== 16'(g_re(n)) || do_im !== 16'(g_im(n))) begin
            if (bad == 0)
               $display("FAIL reorder sample n=%0d do_en=%b re=%0d im=%0d want 1/%0d/%0d",
                        n, do_en, $signed(do_re), $signed(do_im), g_re(n), g_im(n));
            bad++;
         end
         di_en = (n == 10);
         step();
      end
      di_en = 1'b0;
      n_checks++;
      if (bad !== 0) $display("FAIL reorder bad_samples got=%0d want=0", bad);
      else n_pass++;
      n_checks++;
      if (do_en !== 1'b0) $display("FAIL reorder do_en_end got=%b want=0", do_en);
      else n_pass++;
      n_checks++;
      if (overrun !== 1'b1 || busy !== 1'b0)
         $display("FAIL reorder overrun=%b busy=%b want 1/0", overrun, busy);
      else n_pass++;
   endtask
`else
   task automatic test_tie_offs();
      n_checks++;
      if (do_en !== 1'b0 || do_re !== 16'd0 || do_im !== 16'd0 || overrun !== 1'b0)
         $display("FAIL tie_offs do_en=%b re=%0d im=%0d ovr=%b want 0", do_en, do_re, do_im, overrun);
      else n_pass++;
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      di_en = 1'b0;
      di_re = '0;
      di_im = '0;
      test_reset();
      test_exact();
      test_window_edge();
      test_plus3();
      test_saturation();
      test_gaps();
`ifndef FFT_CHK_REORDER_EN
      test_back_to_back();
`endif
      test_reset_mid();
`ifdef FFT_CHK_REORDER_EN
      test_reorder();
`else
      test_tie_offs();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fft_stream_checker.md
# fft_stream_checker

On-chip self-checking monitor for the FFT output stream. Accepts one frame of N complex samples in bit-reversed order and fetches the matching golden value from a synchronous ROM. Compares real and imaginary parts against a ±TOL window and reports the per-frame error count, the maximum absolute error and a pass flag. Sits beside the FFT core for BIST and FPGA bring-up, replacing simulation-only comparison with synthesizable checking.

## Interface
- N, 128, FFT points; power of two, 8..4096; NN = log2(N).
- DW, 16, signed sample width.
- TOL, 2, maximum permitted |golden − dut| per component, in LSBs.
- ERRW, 8, error-counter width; the counter saturates.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- di_en  in  1  sample valid; low cycles stall the frame.
- di_re / di_im  in  DW  signed FFT output, bit-reversed order.
- gold_addr  out  NN  golden ROM address, natural order.
- gold_re / gold_im  in  DW  golden data, valid one cycle after gold_addr.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame verdict is final.
- pass  out  1  last frame had err_cnt == 0.
- err_cnt  out  ERRW  component errors in the last or current frame.
- max_err  out  DW+1  largest |diff| seen in the frame (unsigned).
- frame_cnt  out  16  completed frames; wraps at 2^16.
- do_en, do_re, do_im, overrun  out  1/DW/DW/1  natural-order readout (see Configuration).

## Operation
- Counter k (NN bits) counts accepted samples (di_en=1). gold_addr = bitrev(k).
- Stage 1 registers di_re/di_im. Stage 2 computes signed diffs at DW+1 bits, then takes their absolute values.
- A component is in error if |diff| > TOL. Each sample adds 0, 1 or 2 to err_cnt, saturating at 2^ERRW−1.
- max_err holds the running max over both components.
- States:
  - IDLE: goes to RUN on the first di_en.
  - RUN: goes to FLUSH when k wraps from N−1 to 0.
  - FLUSH: waits for the pipeline to drain (2 cycles), pulses done, increments frame_cnt, then returns to IDLE.
- err_cnt and max_err clear on the first accepted sample of a new frame. Between frames they hold the previous frame's values.
- di_en asserted during FLUSH is accepted as sample 0 of the next frame. Results for the old and new frames do not mix.
- di_en gaps inside RUN stall k and the pipeline's accept slots. They do not abort the frame.
- Reset at any time returns to IDLE and sets every output to 0, except gold_addr which also returns to 0.

## Timing
- Sample accepted at cycle t: gold_addr is valid combinationally in cycle t. The error is counted at the edge ending t+2.
- Last sample at t: done pulses in cycle t+3. pass, err_cnt and max_err are final in that cycle.
- busy is high from the cycle after the first accept through the done cycle.
- Back-to-back frames with no gap are supported at full rate (one sample per clock).

## Configuration
- FFT_CHK_REORDER_EN defined:
  - A 2·N×DW buffer stores samples at address bitrev(k).
  - After done, the buffer is streamed in natural order: do_en is high for N consecutive cycles starting the cycle after done, with do_re/do_im = X[0..N−1].
  - Input arriving during the readout is discarded, and overrun sets sticky until reset.
- Not defined: no buffer. do_en, do_re, do_im and overrun are tied to 0.

## Structure
- Package fft_chk_pkg holds:
  - the bitrev function (parametrised on NN);
  - the state enum {IDLE, RUN, FLUSH};
  - the abs_diff function;
  - the default constants for N, DW and TOL.
- One sub-module, fft_chk_reorder_buf: a dual-port RAM plus readout counter, instantiated only under FFT_CHK_REORDER_EN.

## Test plan
- Exact match, N=128, DUT data = ROM data in bit-reversed order → done at last-accept+3, pass=1, err_cnt=0, max_err=0, frame_cnt=1.
- Diffs at the window edge: diffs of +2 and −2 on all re components pass (err_cnt=0, max_err=2). Diffs of +3 on samples 5 and 77, re and im → err_cnt=4, pass=0, max_err=3.
- Saturation: every component off by 100 (256 errors) → err_cnt=255, max_err=100.
- Gaps and back-to-back frames:
  - di_en toggling 1/0 throughout → same verdict as the gap-free case.
  - Two frames with zero gap → two done pulses 128 cycles apart, independent err_cnt, frame_cnt=2.
- Reset at sample 60 → all outputs return to 0. The next full frame then yields a correct verdict and frame_cnt=1.
- With FFT_CHK_REORDER_EN: input X[bitrev(k)] → do_re/do_im = X[0..127] in order. A frame started during the readout sets overrun=1.
